// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE grants one requester, ACCESS drives memory, RESP returns the result.
// Define DMEM_ARBITER_RR_EN for round-robin tie-breaking; the default is fixed priority with port 0 winning.
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_WriteData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_ReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              owner;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              pick0;
  logic              in_range;

  assign in_range = (op_addr < ADDR_W'(DEPTH));

`ifdef DMEM_ARBITER_RR_EN
  // last_gnt = 1 means port 1 was served last, so port 0 wins the next tie
  logic last_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_gnt <= 1'b1;
    else if (p0_gnt) last_gnt <= 1'b0;
    else if (p1_gnt) last_gnt <= 1'b1;
  end

  assign pick0 = p0_req && (!p1_req || last_gnt);
`else
  assign pick0 = p0_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    mem_MemWrite = 1'b0;
    mem_MemRead  = 1'b0;
    case (state)
      IDLE: begin
        // gated by rst so nothing leaks out while reset is asserted
        p0_gnt = rst && pick0;
        p1_gnt = rst && p1_req && !pick0;
        if (p0_gnt || p1_gnt) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_MemWrite = in_range && op_we;
        mem_MemRead  = in_range && !op_we;
        state_nxt    = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (p0_gnt) begin
        owner    <= 1'b0;
        op_we    <= p0_we;
        op_addr  <= p0_addr;
        op_wdata <= p0_wdata;
      end else if (p1_gnt) begin
        owner    <= 1'b1;
        op_we    <= p1_we;
        op_addr  <= p1_addr;
        op_wdata <= p1_wdata;
      end
      if (state == ACCESS) begin
        rdata_q <= (in_range && !op_we) ? mem_ReadData : '0;
        err_q   <= !in_range;
      end
    end
  end

  assign mem_address   = op_addr;
  assign mem_WriteData = op_wdata;

  assign p0_rsp_valid = (state == RESP) && !owner;
  assign p1_rsp_valid = (state == RESP) && owner;
  assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;
  assign p0_rsp_err   = p0_rsp_valid && err_q;
  assign p1_rsp_err   = p1_rsp_valid && err_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, address width of requester and memory ports.
REQ-002 SHALL have parameter: DATA_W, 64, data width.
REQ-003 SHALL have parameter: DEPTH, 1024, number of data-memory words; legal addresses are 0..DEPTH-1.
REQ-004 clk  input  1  one clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 pN_req  input  1  access request from requester N (N=0 core, N=1 debug/DMA); held until granted.
REQ-007 pN_we  input  1  1 = write, 0 = read; qualified by pN_req.
REQ-008 pN_addr  input  ADDR_W  word address.
REQ-009 pN_wdata  input  DATA_W  write data.
REQ-010 pN_gnt  output  1  request accepted this cycle (combinational, IDLE only).
REQ-011 pN_rsp_valid  output  1  one-cycle pulse: access complete.
REQ-012 pN_rsp_rdata  output  DATA_W  read data, valid with pN_rsp_valid.
REQ-013 pN_rsp_err  output  1  address out of range, valid with pN_rsp_valid.
REQ-014 mem_address / mem_WriteData  output  ADDR_W / DATA_W  to data memory.
REQ-015 mem_MemWrite / mem_MemRead  output  1 / 1  memory strobes.
REQ-016 mem_ReadData  input  DATA_W  combinational read data from memory.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any grant, ACCESS->RESP always, RESP->IDLE always.
REQ-018 In IDLE, at most one pN_gnt SHALL assert; the granted request's we/addr/wdata and owner SHALL be latched at that edge.
REQ-019 In ACCESS, mem strobes SHALL reflect the latched op for exactly one cycle; mem_ReadData SHALL be registered on that edge.
REQ-020 In RESP, owner's pN_rsp_valid SHALL be 1 for exactly one cycle; other port's rsp_valid SHALL be 0.
REQ-021 Latency: req granted in cycle T -> memory access cycle T+1 -> rsp_valid cycle T+2; next grant earliest T+3.
REQ-022 Outside ACCESS, mem_MemWrite and mem_MemRead SHALL be 0; mem_address/mem_WriteData hold latched values.
REQ-023 Latched addr >= DEPTH: no strobe in ACCESS; response rsp_err=1, rsp_rdata=0.
REQ-024 Writes SHALL respond with rsp_rdata=0, rsp_err=0 (in range).
REQ-025 Requests arriving in ACCESS/RESP SHALL wait; no grant outside IDLE.
REQ-026 pN_rsp_rdata and pN_rsp_err SHALL be 0 whenever pN_rsp_valid is 0.

Reset
REQ-027 rst low SHALL immediately force IDLE, clear owner and latched op to 0, all outputs 0.
REQ-028 Reset mid-ACCESS SHALL abort: strobes drop asynchronously, no response issued after release.

Configuration
REQ-029 Macro DMEM_ARBITER_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; last-granted pointer resets to 1 (port 0 wins first tie).
REQ-030 DMEM_ARBITER_RR_EN undefined: fixed priority, port 0 always wins ties; no pointer state.

Verification
REQ-031 p0 write addr 5 data 0xA5, then p0 read addr 5 -> gnt T, mem_MemWrite=1 at T+1 only, later read rsp_rdata=0xA5 at grant+2, err=0.
REQ-032 p1 read addr 1024 -> no mem strobe, p1_rsp_valid with err=1, rdata=0.
REQ-033 p0,p1 request every cycle -> RR_EN: grants alternate 0,1,0,1 every 3 cycles; without macro: only p0 granted.
REQ-034 Request in ACCESS cycle -> no gnt until next IDLE, served 3 cycles after prior grant.
REQ-035 rst low during ACCESS of write addr 7 -> strobes 0 immediately, no rsp_valid after release, FSM in IDLE.
